uart_program_loader: RTL and testbench

- Serial writer for the processor's program (text) memory: receives 8N1 UART bytes, assembles instruction words, and drives the memory write port (`program_write`, `program_cmd`, `uart_address`) with auto-incrementing addresses.
- Also controls `cpu_hold` through control bytes, so the host holds the core in reset while the program is loaded.

---
 rtl/uart_program_loader_if.sv | 16 +
 rtl/uart_program_loader.sv | 90 +++++++++
 tb/tb_uart_program_loader.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/uart_program_loader_if.sv
// uart_program_loader_if: serial input, program-memory write port and loader status
interface uart_program_loader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int INSTRUCTION_WIDTH = 4,
  parameter int DATA_WIDTH = ADDR_WIDTH + INSTRUCTION_WIDTH
);
  logic rx;
  logic program_write;
  logic [DATA_WIDTH-1:0] program_cmd;
  logic [ADDR_WIDTH-1:0] uart_address;
  logic cpu_hold;
  logic frame_error;
  logic busy;
  modport master (input rx, output program_write, program_cmd, uart_address, cpu_hold, frame_error, busy);
  modport slave (output rx, input program_write, program_cmd, uart_address, cpu_hold, frame_error, busy);
endinterface

// File: rtl/uart_program_loader.sv
// uart_program_loader: 8N1 UART receiver that assembles {opcode, operand} words into program memory
module uart_program_loader #(
  parameter int CLKS_PER_BIT = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int INSTRUCTION_WIDTH = 4,
  parameter int DATA_WIDTH = ADDR_WIDTH + INSTRUCTION_WIDTH
) (
  input logic clk,
  input logic reset,
  uart_program_loader_if.master bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {C_HI, C_LO} cmd_state_t;
  rx_state_t rx_state;
  cmd_state_t cmd_state;
  logic rx_meta, rx_s, rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic [INSTRUCTION_WIDTH-1:0] opcode;
  logic last, stop_tick, byte_valid, bad_stop;
  always_comb begin
    last = cnt == CW'(rx_state == RX_START ? CLKS_PER_BIT / 2 - 1 : CLKS_PER_BIT - 1);
    stop_tick = rx_state == RX_STOP && last;
    byte_valid = stop_tick && rx_s;
    bad_stop = stop_tick && !rx_s;
  end
  assign bus.busy = rx_state != RX_IDLE;
  // byte_valid is the stop-bit sample itself, so the write strobe lands one cycle later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {rx_meta, rx_s, rx_prev} <= 3'b111;
      rx_state <= RX_IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
      bus.frame_error <= 1'b0;
    end else begin
      rx_meta <= bus.rx;
      rx_s <= rx_meta;
      rx_prev <= rx_s;
      bus.frame_error <= bad_stop;
      cnt <= (rx_state == RX_IDLE || last) ? '0 : cnt + CW'(1);
      case (rx_state)
        RX_IDLE: if (rx_prev && !rx_s) rx_state <= RX_START;
        RX_START: begin
          bit_idx <= '0;
          if (last) rx_state <= rx_s ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (last) begin
          shift <= {rx_s, shift[7:1]};
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) rx_state <= RX_STOP;
        end
        default: if (last) rx_state <= RX_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_state <= C_HI;
      opcode <= '0;
      bus.program_write <= 1'b0;
      bus.program_cmd <= '0;
      bus.uart_address <= '0;
      bus.cpu_hold <= 1'b0;
    end else begin
      bus.program_write <= 1'b0;
      if (bus.program_write) bus.uart_address <= bus.uart_address + ADDR_WIDTH'(1);
      if (bad_stop) cmd_state <= C_HI;
      else if (byte_valid) begin
        if (cmd_state == C_LO) begin
          cmd_state <= C_HI;
          if (bus.cpu_hold) begin
            bus.program_cmd <= DATA_WIDTH'({opcode, shift});
            bus.program_write <= 1'b1;
          end
        end else if (shift == 8'h40) begin
          bus.uart_address <= '0;
          bus.cpu_hold <= 1'b1;
        end else if (shift == 8'h41) bus.cpu_hold <= 1'b0;
        else if (shift[7]) begin
          opcode <= shift[INSTRUCTION_WIDTH-1:0];
          cmd_state <= C_LO;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader: directed UART byte streams with hand-computed program writes
module tb_uart_program_loader;
  localparam int CPB = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  logic [19:0] wq[$];
  always #5 clk = ~clk;
  uart_program_loader_if bus();
  uart_program_loader #(.CLKS_PER_BIT(CPB)) dut (.clk(clk), .reset(reset), .bus(bus.master));
  always @(negedge clk) begin
    if (bus.program_write) wq.push_back({bus.uart_address, bus.program_cmd});
    if (bus.frame_error) fe_cnt++;
  end
  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk) bus.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.rx = stop;
    repeat (CPB) @(negedge clk);
    bus.rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask
  task automatic test_reset;
    reset = 1'b0;
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.program_write !== 1'b0) begin errors++; $display("FAIL reset_write got %b want 0", bus.program_write); end
    checks++; if (bus.program_cmd !== 12'h000) begin errors++; $display("FAIL reset_cmd got %h want 000", bus.program_cmd); end
    checks++; if (bus.uart_address !== 8'h00) begin errors++; $display("FAIL reset_addr got %h want 00", bus.uart_address); end
    checks++; if (bus.cpu_hold !== 1'b0) begin errors++; $display("FAIL reset_hold got %b want 0", bus.cpu_hold); end
    checks++; if (bus.frame_error !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", bus.frame_error); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    reset = 1'b1;
  endtask
  task automatic test_idle;
    int busy_seen = 0;
    repeat (1000) @(negedge clk) if (bus.busy) busy_seen++;
    checks++; if (wq.size() != 0) begin errors++; $display("FAIL idle_writes got %0d want 0", wq.size()); end
    checks++; if (busy_seen != 0) begin errors++; $display("FAIL idle_busy got %0d busy cycles want 0", busy_seen); end
    checks++; if (fe_cnt != 0) begin errors++; $display("FAIL idle_ferr got %0d want 0", fe_cnt); end
  endtask
  task automatic test_load;
    send_byte(8'h40, 1'b1);
    send_byte(8'h85, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h8A, 1'b1);
    send_byte(8'hFF, 1'b1);
    checks++; if (bus.cpu_hold !== 1'b1) begin errors++; $display("FAIL load_hold got %b want 1", bus.cpu_hold); end
    checks++; if (wq.size() != 2) begin errors++; $display("FAIL load_count got %0d want 2", wq.size()); end
    else begin
      checks++; if (wq[0] !== 20'h0053C) begin errors++; $display("FAIL load_w0 got %h want 0053c", wq[0]); end
      checks++; if (wq[1] !== 20'h01AFF) begin errors++; $display("FAIL load_w1 got %h want 01aff", wq[1]); end
    end
    checks++; if (bus.uart_address !== 8'd2) begin errors++; $display("FAIL load_addr got %0d want 2", bus.uart_address); end
    wq.delete();
  endtask
  task automatic test_hold_gate;
    send_byte(8'h41, 1'b1);
    checks++; if (bus.cpu_hold !== 1'b0) begin errors++; $display("FAIL run_hold got %b want 0", bus.cpu_hold); end
    send_byte(8'h81, 1'b1);
    send_byte(8'h01, 1'b1);
    checks++; if (wq.size() != 0) begin errors++; $display("FAIL gate_writes got %0d want 0", wq.size()); end
    checks++; if (bus.uart_address !== 8'd2) begin errors++; $display("FAIL gate_addr got %0d want 2", bus.uart_address); end
    checks++; if (bus.program_cmd !== 12'hAFF) begin errors++; $display("FAIL gate_cmd got %h want aff", bus.program_cmd); end
    wq.delete();
  endtask
  task automatic test_frame_error;
    int fe0;
    send_byte(8'h40, 1'b1);
    fe0 = fe_cnt;
    send_byte(8'h83, 1'b0);
    checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL ferr_pulses got %0d want 1", fe_cnt - fe0); end
    checks++; if (wq.size() != 0) begin errors++; $display("FAIL ferr_writes got %0d want 0", wq.size()); end
    send_byte(8'h84, 1'b1);
    send_byte(8'h10, 1'b1);
    checks++; if (wq.size() != 1) begin errors++; $display("FAIL ferr_count got %0d want 1", wq.size()); end
    else begin
      checks++; if (wq[0] !== 20'h00410) begin errors++; $display("FAIL ferr_w0 got %h want 00410", wq[0]); end
    end
    checks++; if (bus.uart_address !== 8'd1) begin errors++; $display("FAIL ferr_addr got %0d want 1", bus.uart_address); end
    wq.delete();
  endtask
  task automatic test_glitch;
    int fe0 = fe_cnt;
    int busy_seen = 0;
    @(negedge clk) bus.rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    bus.rx = 1'b1;
    repeat (CPB * 3) @(negedge clk) if (bus.busy) busy_seen++;
    checks++; if (busy_seen == 0) begin errors++; $display("FAIL glitch_start got 0 busy cycles want >0"); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b want 0", bus.busy); end
    checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL glitch_ferr got %0d want %0d", fe_cnt, fe0); end
    checks++; if (wq.size() != 0) begin errors++; $display("FAIL glitch_writes got %0d want 0", wq.size()); end
  endtask
  task automatic test_wrap;
    logic [7:0] k;
    logic [19:0] exp;
    send_byte(8'h40, 1'b1);
    for (int i = 0; i < 256; i++) begin
      k = 8'(i);
      send_byte({4'h8, k[3:0]}, 1'b1);
      send_byte(k ^ 8'h5A, 1'b1);
    end
    checks++; if (wq.size() != 256) begin errors++; $display("FAIL wrap_count got %0d want 256", wq.size()); end
    else for (int i = 0; i < 256; i++) begin
      k = 8'(i);
      exp = {k, k[3:0], k ^ 8'h5A};
      checks++; if (wq[i] !== exp) begin errors++; $display("FAIL wrap_w%0d got %h want %h", i, wq[i], exp); end
    end
    checks++; if (bus.uart_address !== 8'd0) begin errors++; $display("FAIL wrap_addr got %0d want 0", bus.uart_address); end
    wq.delete();
    send_byte(8'h87, 1'b1);
    send_byte(8'h00, 1'b1);
    checks++; if (wq.size() != 1) begin errors++; $display("FAIL over_count got %0d want 1", wq.size()); end
    else begin
      checks++; if (wq[0] !== 20'h00700) begin errors++; $display("FAIL over_w0 got %h want 00700", wq[0]); end
    end
    checks++; if (bus.uart_address !== 8'd1) begin errors++; $display("FAIL over_addr got %0d want 1", bus.uart_address); end
  endtask
  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    bus.rx = 1'b1;
    test_reset();
    test_idle();
    test_load();
    test_hold_gate();
    test_frame_error();
    test_glitch();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
